// File: rtl/axil_reg_bank.sv
// AXI4-Lite slave register bank: byte-strobe writes, SLVERR decode, stallable command doorbell.
// Optional sticky completion interrupt on the last register when AXIL_REG_IRQ_EN is defined.
module axil_reg_bank #(
  parameter int          ADDR_W    = 12,
  parameter int          DATA_W    = 32,
  parameter int          NUM_REGS  = 32,
  parameter int          CMD_IDX   = 0,
  parameter logic [31:0] CMD_RESET = 32'hDEADBEEF
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [ADDR_W-1:0]            s_awaddr,
  input  logic                         s_awvalid,
  output logic                         s_awready,
  input  logic [DATA_W-1:0]            s_wdata,
  input  logic [DATA_W/8-1:0]          s_wstrb,
  input  logic                         s_wvalid,
  output logic                         s_wready,
  output logic [1:0]                   s_bresp,
  output logic                         s_bvalid,
  input  logic                         s_bready,
  input  logic [ADDR_W-1:0]            s_araddr,
  input  logic                         s_arvalid,
  output logic                         s_arready,
  output logic [DATA_W-1:0]            s_rdata,
  output logic [1:0]                   s_rresp,
  output logic                         s_rvalid,
  input  logic                         s_rready,
  output logic [NUM_REGS*DATA_W-1:0]   ctrl_regs,
  output logic [7:0]                   cmd,
  output logic                         cmd_new,
  input  logic                         cmd_busy,
  input  logic [NUM_REGS*DATA_W-1:0]   status_regs,
  input  logic                         done_pulse,
  output logic                         irq
);

  localparam int STRB_W = DATA_W / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(NUM_REGS);

  localparam logic [IDX_W:0]        REG_COUNT = (IDX_W+1)'(NUM_REGS);
  localparam logic [IDX_W-1:0]      CMD_SEL   = IDX_W'(CMD_IDX);
  localparam logic [IDX_W-1:0]      LAST_SEL  = IDX_W'(NUM_REGS - 1);
  localparam logic [DATA_W-1:0]     CMD_INIT  = DATA_W'(CMD_RESET);

  localparam logic [1:0] W_IDLE   = 2'd0;
  localparam logic [1:0] W_HALF   = 2'd1;
  localparam logic [1:0] W_COMMIT = 2'd2;
  localparam logic [1:0] W_RESP   = 2'd3;
  localparam logic       R_IDLE   = 1'b0;
  localparam logic       R_DATA   = 1'b1;

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
    return IDX_W'(a >> LSB);
  endfunction

  // Out of range when the index exceeds the bank or any bit above the index field is set.
  function automatic logic addr_err(input logic [ADDR_W-1:0] a);
    return ({1'b0, IDX_W'(a >> LSB)} >= REG_COUNT) || ((a >> (LSB + IDX_W)) != '0);
  endfunction

  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  logic [1:0]          w_state;
  logic                r_state;
  logic [ADDR_W-1:0]   aw_addr;
  logic [DATA_W-1:0]   w_data;
  logic [STRB_W-1:0]   w_strb;
  logic                aw_hs, w_hs, ar_hs;
  logic [IDX_W-1:0]    w_idx, r_idx;
  logic                w_err, r_err, w_is_cmd, w_stall, w_fire;
  logic [DATA_W-1:0]   r_word;

  assign aw_hs    = s_awvalid & s_awready;
  assign w_hs     = s_wvalid & s_wready;
  assign ar_hs    = s_arvalid & s_arready;
  assign w_idx    = addr_idx(aw_addr);
  assign w_err    = addr_err(aw_addr);
  assign w_is_cmd = !w_err && (w_idx == CMD_SEL);
  assign w_stall  = w_is_cmd && cmd_busy;
  assign w_fire   = (w_state == W_COMMIT) && !w_stall;
  assign r_idx    = addr_idx(s_araddr);
  assign r_err    = addr_err(s_araddr);

  assign ctrl_regs = regs;
  assign cmd       = regs[CMD_IDX][7:0];

`ifdef AXIL_REG_IRQ_EN
  logic pending, irq_clear;
  assign pending   = regs[NUM_REGS-1][0];
  assign irq_clear = w_fire && !w_err && (w_idx == LAST_SEL) && w_strb[0] && w_data[0];
  assign irq       = pending;
`else
  assign irq = done_pulse & 1'b0;
`endif

  always_comb begin
    r_word = '0;
    if (!r_err) begin
      r_word = status_regs[int'(r_idx) * DATA_W +: DATA_W];
`ifdef AXIL_REG_IRQ_EN
      if (r_idx == LAST_SEL) r_word[0] = pending;
`endif
    end
  end

  // The pending flag is owned by done_pulse/W1C, so it overrides any byte write to bit 0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      regs          <= '0;
      regs[CMD_IDX] <= CMD_INIT;
    end else begin
      if (w_fire && !w_err) begin
        for (int k = 0; k < STRB_W; k++) begin
          if (w_strb[k]) regs[w_idx][8*k +: 8] <= w_data[8*k +: 8];
        end
      end
`ifdef AXIL_REG_IRQ_EN
      regs[NUM_REGS-1][0] <= done_pulse | (pending & !irq_clear);
`endif
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_state   <= W_IDLE;
      s_awready <= 1'b1;
      s_wready  <= 1'b1;
      s_bvalid  <= 1'b0;
      s_bresp   <= 2'b00;
      cmd_new   <= 1'b0;
      aw_addr   <= '0;
      w_data    <= '0;
      w_strb    <= '0;
    end else begin
      cmd_new <= 1'b0;
      if (aw_hs) begin
        aw_addr   <= s_awaddr;
        s_awready <= 1'b0;
      end
      if (w_hs) begin
        w_data   <= s_wdata;
        w_strb   <= s_wstrb;
        s_wready <= 1'b0;
      end
      case (w_state)
        W_IDLE: begin
          if (aw_hs && w_hs)      w_state <= W_COMMIT;
          else if (aw_hs || w_hs) w_state <= W_HALF;
        end
        W_HALF: begin
          if ((!s_awready || aw_hs) && (!s_wready || w_hs)) w_state <= W_COMMIT;
        end
        W_COMMIT: begin
          if (!w_stall) begin
            s_bvalid <= 1'b1;
            s_bresp  <= w_err ? 2'b10 : 2'b00;
            cmd_new  <= w_is_cmd;
            w_state  <= W_RESP;
          end
        end
        W_RESP: begin
          if (s_bready) begin
            s_bvalid  <= 1'b0;
            s_awready <= 1'b1;
            s_wready  <= 1'b1;
            w_state   <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= R_IDLE;
      s_arready <= 1'b1;
      s_rvalid  <= 1'b0;
      s_rdata   <= '0;
      s_rresp   <= 2'b00;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            s_rdata   <= r_word;
            s_rresp   <= r_err ? 2'b10 : 2'b00;
            s_rvalid  <= 1'b1;
            s_arready <= 1'b0;
            r_state   <= R_DATA;
          end
        end
        default: begin
          if (s_rready) begin
            s_rvalid  <= 1'b0;
            s_arready <= 1'b1;
            r_state   <= R_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axil_reg_bank.sv
// Directed scoreboard bench for axil_reg_bank (default parameters).
// Build with AXIL_REG_IRQ_EN defined to exercise the interrupt flag as well.
module tb_axil_reg_bank;

  localparam int ADDR_W   = 12;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;
  localparam int STRB_W   = DATA_W / 8;

  logic                       clk = 1'b0;
  logic                       rstn = 1'b0;
  logic [ADDR_W-1:0]          s_awaddr, s_araddr;
  logic                       s_awvalid, s_awready, s_wvalid, s_wready;
  logic [DATA_W-1:0]          s_wdata, s_rdata;
  logic [STRB_W-1:0]          s_wstrb;
  logic [1:0]                 s_bresp, s_rresp;
  logic                       s_bvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rready;
  logic [NUM_REGS*DATA_W-1:0] ctrl_regs, status_regs;
  logic [7:0]                 cmd;
  logic                       cmd_new, cmd_busy, done_pulse, irq;

  always #5 clk = ~clk;

  axil_reg_bank dut (
    .clk(clk), .rstn(rstn),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .ctrl_regs(ctrl_regs), .cmd(cmd), .cmd_new(cmd_new), .cmd_busy(cmd_busy),
    .status_regs(status_regs), .done_pulse(done_pulse), .irq(irq)
  );

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  logic [1:0]        exp_b[$];
  logic [DATA_W+1:0] exp_r[$];
  logic [DATA_W-1:0] model [NUM_REGS];
  logic [DATA_W-1:0] status_model [NUM_REGS];
  logic              exp_pending = 1'b0;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_status
    assign status_regs[g*DATA_W +: DATA_W] = status_model[g];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [DATA_W-1:0] ctrl_word(input int i);
    return ctrl_regs[i*DATA_W +: DATA_W];
  endfunction

  function automatic logic oor(input logic [ADDR_W-1:0] a);
    return int'(a >> 2) >= NUM_REGS;
  endfunction

  // Compares the first register that disagrees with the model (or register 0 if none do).
  task automatic checkCtrl(input string tag);
    int first = 0;
    for (int i = NUM_REGS - 1; i >= 0; i--) if (ctrl_word(i) !== model[i]) first = i;
    checkOutput({tag, "_ctrl"}, ctrl_word(first), model[first]);
  endtask

  task automatic expectWrite(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic [STRB_W-1:0] s);
    int idx = int'(a >> 2);
    if (oor(a)) exp_b.push_back(2'b10);
    else begin
      exp_b.push_back(2'b00);
      for (int k = 0; k < STRB_W; k++) if (s[k]) model[idx][8*k +: 8] = d[8*k +: 8];
`ifdef AXIL_REG_IRQ_EN
      if (idx == NUM_REGS - 1) begin
        if (s[0] && d[0]) exp_pending = 1'b0;
        model[idx][0] = exp_pending;
      end
`endif
    end
  endtask

  task automatic expectRead(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] w;
    int idx = int'(a >> 2);
    if (oor(a)) exp_r.push_back({{DATA_W{1'b0}}, 2'b10});
    else begin
      w = status_model[idx];
`ifdef AXIL_REG_IRQ_EN
      if (idx == NUM_REGS - 1) w[0] = exp_pending;
`endif
      exp_r.push_back({w, 2'b00});
    end
  endtask

  // mode 0: AW and W together, 1: AW one cycle ahead, 2: W one cycle ahead
  task automatic applyStimulus(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                               input logic [STRB_W-1:0] s, input int mode);
    expectWrite(a, d, s);
    s_awaddr = a;
    s_wdata  = d;
    s_wstrb  = s;
    case (mode)
      1: begin
        s_awvalid = 1'b1; tick(); s_awvalid = 1'b0;
        s_wvalid = 1'b1;  tick(); s_wvalid = 1'b0;
      end
      2: begin
        s_wvalid = 1'b1;  tick(); s_wvalid = 1'b0;
        s_awvalid = 1'b1; tick(); s_awvalid = 1'b0;
      end
      default: begin
        s_awvalid = 1'b1; s_wvalid = 1'b1; tick();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
      end
    endcase
  endtask

  task automatic issueRead(input logic [ADDR_W-1:0] a);
    expectRead(a);
    s_araddr  = a;
    s_arvalid = 1'b1;
    tick();
    s_arvalid = 1'b0;
  endtask

  task automatic waitB(input string tag);
    int n = 0;
    while (!s_bvalid && n < 100) begin tick(); n++; end
    checkOutput({tag, "_bvalid"}, s_bvalid, 1);
    if (exp_b.size() != 0) checkOutput({tag, "_bresp"}, s_bresp, exp_b.pop_front());
    s_bready = 1'b1;
    tick();
    s_bready = 1'b0;
    checkCtrl(tag);
  endtask

  task automatic waitR(input string tag);
    int n = 0;
    while (!s_rvalid && n < 100) begin tick(); n++; end
    checkOutput({tag, "_rvalid"}, s_rvalid, 1);
    if (exp_r.size() != 0) checkOutput({tag, "_rdata"}, {s_rdata, s_rresp}, exp_r.pop_front());
    s_rready = 1'b1;
    tick();
    s_rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
    s_bready = 1'b0; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
    cmd_busy = 1'b0; done_pulse = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      status_model[i] = {16'hCAFE, 8'h00, 8'(i)};
      model[i] = '0;
    end
    model[0] = 32'hDEADBEEF;

    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    tick();
    checkOutput("rst_readies", {s_awready, s_wready, s_arready}, 3'b111);
    checkOutput("rst_valids", {s_bvalid, s_rvalid, cmd_new, irq}, 4'b0000);
    checkOutput("rst_resp_data", {s_bresp, s_rresp, s_rdata}, 36'h0);
    checkOutput("rst_reg0", ctrl_word(0), 32'hDEADBEEF);
    checkOutput("rst_cmd", cmd, 8'hEF);
    checkCtrl("rst");

    // reset in the middle of a half-captured write drops it
    s_awaddr = 12'h004; s_awvalid = 1'b1; tick(); s_awvalid = 1'b0;
    checkOutput("abort_awready_low", s_awready, 0);
    rstn = 1'b0; tick(); tick(); rstn = 1'b1;
    repeat (3) tick();
    checkOutput("abort_state", {s_awready, s_wready, s_bvalid}, 3'b110);
    checkCtrl("abort");

    // W beat two cycles ahead of AW
    expectWrite(12'h008, 32'h11223344, 4'b0101);
    s_wdata = 32'h11223344; s_wstrb = 4'b0101; s_wvalid = 1'b1; tick(); s_wvalid = 1'b0;
    checkOutput("wfirst_readies", {s_awready, s_wready}, 2'b10);
    tick();
    s_awaddr = 12'h008; s_awvalid = 1'b1; tick(); s_awvalid = 1'b0;
    checkOutput("wfirst_bvalid_early", s_bvalid, 0);
    tick();
    checkOutput("wfirst_bvalid", s_bvalid, 1);
    checkOutput("wfirst_reg2", ctrl_word(2), 32'h00220044);
    waitB("wfirst");
    checkOutput("wfirst_readies_back", {s_awready, s_wready}, 2'b11);

    applyStimulus(12'h008, 32'hAABBCCDD, 4'b1010, 1);
    waitB("awfirst");
    checkOutput("awfirst_reg2", ctrl_word(2), 32'hAA22CC44);
    applyStimulus(12'h07C, 32'h87654321, 4'b1111, 0);
    waitB("last_reg");

    applyStimulus(12'h080, 32'hFFFFFFFF, 4'b1111, 0);
    waitB("oor_write");
    applyStimulus(12'h800, 32'hFFFFFFFF, 4'b1111, 2);
    waitB("oor_high_write");
    issueRead(12'h080); waitR("oor_read");
    issueRead(12'h014); waitR("read5");
    issueRead(12'h017); waitR("read5_lowbits");
    issueRead(12'h07C); waitR("read_last");
    issueRead(12'h804); waitR("oor_high_read");

    // doorbell held off while the engine is busy
    cmd_busy = 1'b1;
    expectWrite(12'h000, 32'h0000005A, 4'b0001);
    s_awaddr = 12'h000; s_wdata = 32'h0000005A; s_wstrb = 4'b0001;
    s_awvalid = 1'b1; s_wvalid = 1'b1; tick(); s_awvalid = 1'b0; s_wvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("db_stall", {s_bvalid, cmd_new, ctrl_word(0)}, {1'b0, 1'b0, 32'hDEADBEEF});
    end
    cmd_busy = 1'b0;
    tick();
    checkOutput("db_pulse", {cmd_new, s_bvalid, cmd}, {1'b1, 1'b1, 8'h5A});
    checkOutput("db_reg0", ctrl_word(0), 32'hDEADBE5A);
    tick();
    checkOutput("db_pulse_once", cmd_new, 0);
    waitB("db");

    // read and write in flight together, each with its own handshake
    expectWrite(12'h010, 32'h12345678, 4'b1111);
    expectRead(12'h00C);
    s_awaddr = 12'h010; s_wdata = 32'h12345678; s_wstrb = 4'b1111; s_araddr = 12'h00C;
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1; tick();
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    checkOutput("conc_readies", {s_awready, s_wready, s_arready}, 3'b000);
    status_model[3] = 32'h0BAD0BAD;
    tick();
    checkOutput("conc_valids", {s_bvalid, s_rvalid}, 2'b11);
    repeat (3) tick();
    checkOutput("conc_rhold", {s_rvalid, s_rdata}, {1'b1, 32'hCAFE0003});
    waitR("conc_read");
    checkOutput("conc_bhold", {s_bvalid, s_bresp}, 3'b100);
    waitB("conc_write");
    status_model[3] = 32'hCAFE0003;

`ifdef AXIL_REG_IRQ_EN
    done_pulse = 1'b1; tick(); done_pulse = 1'b0;
    exp_pending = 1'b1; model[NUM_REGS-1][0] = 1'b1;
    checkOutput("irq_set", irq, 1);
    issueRead(12'h07C); waitR("irq_read");
    expectWrite(12'h07C, 32'h00000001, 4'b0001);
    exp_pending = 1'b1; model[NUM_REGS-1][0] = 1'b1;
    s_awaddr = 12'h07C; s_wdata = 32'h00000001; s_wstrb = 4'b0001;
    s_awvalid = 1'b1; s_wvalid = 1'b1; tick(); s_awvalid = 1'b0; s_wvalid = 1'b0;
    done_pulse = 1'b1; tick(); done_pulse = 1'b0;
    checkOutput("irq_collide", irq, 1);
    waitB("irq_collide");
    applyStimulus(12'h07C, 32'h00000001, 4'b0001, 0);
    waitB("irq_clear");
    checkOutput("irq_clear", irq, 0);
`else
    done_pulse = 1'b1; tick(); done_pulse = 1'b0; tick();
    checkOutput("irq_off", irq, 0);
    checkCtrl("irq_off");
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
